hex_display_scanner: RTL and testbench

- Drives a multi-digit, time-multiplexed 7-segment display with active-low segment and digit enables.
- Takes a packed hex value of NUM_DIGITS nibbles and scans one digit at a time at a rate set by a prescaler.
- New loads go into a shadow register and are applied only at a frame boundary, so the display never tears; the block acknowledges each application.
- Optional leading-zero blanking. Sits between the value-producing logic and the board display pins.

---
 rtl/hex_seg_pkg.sv | 13 +
 rtl/hex_seg_decode.sv | 9 +
 rtl/hex_display_scanner.sv | 71 +++++++
 tb/tb_hex_display_scanner.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/hex_seg_pkg.sv
// hex_seg_pkg: shared 7-segment constants and the active-high hex glyph table.
package hex_seg_pkg;
    localparam int SEG_W = 7;
    localparam logic [SEG_W-1:0] SEG_BLANK_N = 7'h7F;
    // Bit 6 = a ... bit 0 = g, active-high.
    localparam logic [SEG_W-1:0] HEX_SEG [16] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
        7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
    };
    function automatic logic [SEG_W-1:0] hex_to_seg(input logic [3:0] nibble);
        return HEX_SEG[nibble];
    endfunction
endpackage

// File: rtl/hex_seg_decode.sv
// hex_seg_decode: combinational nibble to active-low 7-segment pattern.
module hex_seg_decode
    import hex_seg_pkg::*;
(
    input  logic [3:0]       nibble,
    output logic [SEG_W-1:0] seg_n
);
    assign seg_n = ~hex_to_seg(nibble);
endmodule

// File: rtl/hex_display_scanner.sv
// hex_display_scanner: time-multiplexed hex display driver with frame-aligned
// shadow loading and optional leading-zero blanking.
module hex_display_scanner
    import hex_seg_pkg::*;
#(
    parameter int  NUM_DIGITS = 4,
    parameter int  CLK_DIV    = 1024,
    localparam int IDX_W      = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    lz_blank,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] data_in,
    output logic                    load_ack,
    output logic                    pending,
    output logic [SEG_W-1:0]        seg_n,
    output logic [NUM_DIGITS-1:0]   dig_n
);
    localparam int PS_W = $clog2(CLK_DIV);
    logic [PS_W-1:0]         ps;
    logic [IDX_W-1:0]        idx;
    logic [4*NUM_DIGITS-1:0] display, shadow;
    logic [(1<<IDX_W)-1:0]   blank;
    logic [SEG_W-1:0]        seg_dec;
    logic                    tc, last, apply, zero_up;
    assign tc    = en && ps == PS_W'(CLK_DIV - 1);
    assign last  = idx == IDX_W'(NUM_DIGITS - 1);
    // Disabled display has no frame boundary, so apply as soon as possible.
    assign apply = pending && (!en || (tc && last));
    always_comb begin
        zero_up = 1'b1;
        blank   = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_up  = zero_up && display[4*i +: 4] == 4'h0;
            blank[i] = lz_blank && i > 0 && zero_up;
        end
    end
    hex_seg_decode u_dec (
        .nibble (display[4*idx +: 4]),
        .seg_n  (seg_dec)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ps       <= '0;
            idx      <= '0;
            display  <= '0;
            shadow   <= '0;
            pending  <= 1'b0;
            load_ack <= 1'b0;
            seg_n    <= SEG_BLANK_N;
            dig_n    <= '1;
        end else begin
            if (tc) begin
                ps  <= '0;
                idx <= last ? '0 : idx + 1'b1;
            end else if (en) begin
                ps <= ps + 1'b1;
            end
            if (apply)
                display <= shadow;
            if (load)
                shadow <= data_in;
            pending  <= load || (pending && !apply);
            load_ack <= apply;
            dig_n    <= en ? ~(NUM_DIGITS'(1) << idx) : '1;
            seg_n    <= (!en || blank[idx]) ? SEG_BLANK_N : seg_dec;
        end
    end
endmodule

// File: tb/tb_hex_display_scanner.sv
// tb_hex_display_scanner: vector table plus scoreboarded frame checks for the scanner.
module tb_hex_display_scanner;
    logic        clk = 1'b0, rst = 1'b0, en = 1'b0, lz_blank = 1'b0, load = 1'b0;
    logic [15:0] data_in = '0;
    logic        load_ack, pending;
    logic [6:0]  seg_n;
    logic [3:0]  dig_n;
    int          n_cmp = 0, n_bad = 0;

    typedef struct packed {logic [3:0] dig; logic [6:0] seg;} exp_t;
    typedef struct {logic [15:0] data; logic lz; logic [27:0] segs;} vec_t;
    exp_t q[$];
    vec_t vecs[8];

    hex_display_scanner #(.NUM_DIGITS(4), .CLK_DIV(4)) dut (
        .clk(clk), .rst(rst), .en(en), .lz_blank(lz_blank), .load(load),
        .data_in(data_in), .load_ack(load_ack), .pending(pending),
        .seg_n(seg_n), .dig_n(dig_n)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // segs packs the active-low pattern of digits {3,2,1,0}; each digit lit 4 cycles.
    task automatic push_frame(input logic [27:0] segs);
        for (int d = 0; d < 4; d++) begin
            logic [3:0] dg;
            dg = ~(4'b0001 << d);
            for (int k = 0; k < 4; k++) q.push_back('{dig: dg, seg: segs[d*7 +: 7]});
        end
    endtask

    task automatic drain();
        exp_t e;
        while (q.size() > 0) begin
            tick();
            e = q.pop_front();
            chk("frame_dig_n", 32'(dig_n), 32'(e.dig));
            chk("frame_seg_n", 32'(seg_n), 32'(e.seg));
            chk("frame_no_ack", 32'(load_ack), 32'd0);
        end
    endtask

    task automatic wait_ack();
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            tick();
            seen = load_ack;
        end
        chk("ack_seen", 32'(seen), 32'd1);
    endtask

    task automatic do_load(input logic [15:0] v);
        data_in = v;
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    initial begin
        int acks;
        vecs[0] = '{16'h3A0F, 1'b0, {7'h06, 7'h08, 7'h01, 7'h38}};
        vecs[1] = '{16'h0050, 1'b1, {7'h7F, 7'h7F, 7'h24, 7'h01}};
        vecs[2] = '{16'h0000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h01}};
        vecs[3] = '{16'h0000, 1'b0, {7'h01, 7'h01, 7'h01, 7'h01}};
        vecs[4] = '{16'h1234, 1'b0, {7'h4F, 7'h12, 7'h06, 7'h4C}};
        vecs[5] = '{16'hFEDC, 1'b0, {7'h38, 7'h30, 7'h42, 7'h31}};
        vecs[6] = '{16'h0700, 1'b1, {7'h7F, 7'h0F, 7'h01, 7'h01}};
        vecs[7] = '{16'h5067, 1'b1, {7'h24, 7'h01, 7'h20, 7'h0F}};

        #2 rst = 1'b1;
        #1;
        chk("rst_seg_n", 32'(seg_n), 32'h7F);
        chk("rst_dig_n", 32'(dig_n), 32'hF);
        chk("rst_ack", 32'(load_ack), 32'd0);
        chk("rst_pending", 32'(pending), 32'd0);
        @(posedge clk);
        tick();
        rst = 1'b0;
        en = 1'b1;
        push_frame({4{7'h01}});
        drain();

        foreach (vecs[i]) begin
            lz_blank = vecs[i].lz;
            do_load(vecs[i].data);
            chk("pending_after_load", 32'(pending), 32'd1);
            wait_ack();
            chk("pending_after_ack", 32'(pending), 32'd0);
            push_frame(vecs[i].segs);
            drain();
        end

        // Two loads in a frame, a third on the wrap edge; drain left us just after a wrap.
        lz_blank = 1'b0;
        acks = 0;
        do_load(16'h1111);
        tick();
        do_load(16'h2222);
        for (int c = 0; c < 12; c++) begin
            tick();
            acks += int'(load_ack);
        end
        chk("no_early_ack", 32'(acks), 32'd0);
        do_load(16'h3333);
        chk("wrap_ack", 32'(load_ack), 32'd1);
        chk("wrap_pending_kept", 32'(pending), 32'd1);
        tick();
        chk("ack_one_cycle", 32'(load_ack), 32'd0);
        chk("shows_2222_seg", 32'(seg_n), 32'h12);
        chk("shows_2222_dig", 32'(dig_n), 32'hE);
        wait_ack();
        chk("pending_cleared", 32'(pending), 32'd0);
        push_frame({4{7'h06}});
        drain();

        // en=0 while pending: immediate apply, dark display, resume at held position.
        for (int c = 0; c < 5; c++) tick();
        do_load(16'h4321);
        en = 1'b0;
        tick();
        chk("dis_ack", 32'(load_ack), 32'd1);
        chk("dis_pending", 32'(pending), 32'd0);
        chk("dis_dig_n", 32'(dig_n), 32'hF);
        chk("dis_seg_n", 32'(seg_n), 32'h7F);
        tick();
        chk("dis_ack_drop", 32'(load_ack), 32'd0);
        chk("dis_dark", 32'(dig_n), 32'hF);
        en = 1'b1;
        tick();
        chk("resume_dig1", 32'(dig_n), 32'hD);
        chk("resume_seg1", 32'(seg_n), 32'h12);
        tick();
        chk("resume_dig1_b", 32'(dig_n), 32'hD);
        tick();
        chk("resume_dig2", 32'(dig_n), 32'hB);
        chk("resume_seg2", 32'(seg_n), 32'h06);

        // Asynchronous reset with a pending value.
        do_load(16'h9999);
        chk("pre_rst_pending", 32'(pending), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_seg_n", 32'(seg_n), 32'h7F);
        chk("arst_dig_n", 32'(dig_n), 32'hF);
        chk("arst_pending", 32'(pending), 32'd0);
        chk("arst_ack", 32'(load_ack), 32'd0);
        @(posedge clk);
        tick();
        rst = 1'b0;
        push_frame({4{7'h01}});
        drain();
        acks = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            acks += int'(load_ack);
        end
        chk("post_rst_no_ack", 32'(acks), 32'd0);
        chk("post_rst_pending", 32'(pending), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
